// File: rtl/sum_block_accumulator.sv
// rtl/sum_block_accumulator.sv - accumulates N_SUMS serial-adder sums into a handshaked block total
// Optional per-block maximum-sum output acc_max is enabled by defining SUM_MAX_TRACK_EN.
module sum_block_accumulator #(
    parameter int SUM_W  = 5,
    parameter int N_SUMS = 4,
    parameter int ACC_W  = 8,
    parameter int CNT_W  = 3
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Done,
    input  logic [SUM_W-1:0] sum,
    output logic [ACC_W-1:0] acc_total,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             overrun
`ifdef SUM_MAX_TRACK_EN
    ,
    output logic [SUM_W-1:0] acc_max
`endif
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SUMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_total_q, acc_total_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             overrun_q, overrun_d;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W:0]   sum_x;
`ifdef SUM_MAX_TRACK_EN
    logic [SUM_W-1:0] acc_max_q, acc_max_d;
`endif

    // One spare bit above the accumulator catches the carry that sets wrap.
    assign sum_ext = (ACC_W+1)'(sum);
    assign sum_x   = {1'b0, acc_total_q} + sum_ext;

    always_comb begin
        state_d     = state_q;
        acc_total_d = acc_total_q;
        count_d     = count_q;
        wrap_d      = wrap_q;
        overrun_d   = overrun_q;
`ifdef SUM_MAX_TRACK_EN
        acc_max_d   = acc_max_q;
`endif
        if (Clear) begin
            state_d     = ACCUM;
            acc_total_d = '0;
            count_d     = '0;
            wrap_d      = 1'b0;
            overrun_d   = 1'b0;
`ifdef SUM_MAX_TRACK_EN
            acc_max_d   = '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (Done) begin
                        acc_total_d = sum_x[ACC_W-1:0];
                        wrap_d      = wrap_q | sum_x[ACC_W];
                        count_d     = count_q + CNT_W'(1);
`ifdef SUM_MAX_TRACK_EN
                        if (sum > acc_max_q) acc_max_d = sum;
`endif
                        if (count_q == LAST_CNT) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        // A Done on the accepting edge becomes the first sum of the next block.
                        if (Done) begin
                            acc_total_d = sum_ext[ACC_W-1:0];
                            count_d     = CNT_W'(1);
                            wrap_d      = 1'b0;
                            state_d     = (N_SUMS == 1) ? HOLD : ACCUM;
`ifdef SUM_MAX_TRACK_EN
                            acc_max_d   = sum;
`endif
                        end else begin
                            acc_total_d = '0;
                            count_d     = '0;
                            wrap_d      = 1'b0;
                            state_d     = ACCUM;
`ifdef SUM_MAX_TRACK_EN
                            acc_max_d   = '0;
`endif
                        end
                    end else if (Done) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ACCUM;
            acc_total_q <= '0;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SUM_MAX_TRACK_EN
            acc_max_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_total_q <= acc_total_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            overrun_q   <= overrun_d;
`ifdef SUM_MAX_TRACK_EN
            acc_max_q   <= acc_max_d;
`endif
        end
    end

    assign acc_total = acc_total_q;
    assign acc_valid = (state_q == HOLD);
    assign count     = count_q;
    assign wrap      = wrap_q;
    assign overrun   = overrun_q;
`ifdef SUM_MAX_TRACK_EN
    assign acc_max   = acc_max_q;
`endif

endmodule

// File: tb/tb_sum_block_accumulator.sv
// tb/tb_sum_block_accumulator.sv - directed table-driven bench for sum_block_accumulator
module tb_sum_block_accumulator;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_n;
    logic       a_clear, a_done, a_ready;
    logic [4:0] a_sum;
    logic [7:0] a_total;
    logic       a_valid, a_wrap, a_ovr;
    logic [2:0] a_count;

    logic       b_clear, b_done, b_ready;
    logic [4:0] b_sum;
    logic [4:0] b_total;
    logic       b_valid, b_wrap, b_ovr;
    logic [2:0] b_count;
`ifdef SUM_MAX_TRACK_EN
    logic [4:0] a_max, b_max;
`endif

    sum_block_accumulator #(.SUM_W(5), .N_SUMS(4), .ACC_W(8), .CNT_W(3)) dut_a (
        .clock(clock), .Reset(rst_n), .Clear(a_clear), .Done(a_done), .sum(a_sum),
        .acc_total(a_total), .acc_valid(a_valid), .acc_ready(a_ready), .count(a_count),
        .wrap(a_wrap), .overrun(a_ovr)
`ifdef SUM_MAX_TRACK_EN
        , .acc_max(a_max)
`endif
    );

    sum_block_accumulator #(.SUM_W(5), .N_SUMS(4), .ACC_W(5), .CNT_W(3)) dut_b (
        .clock(clock), .Reset(rst_n), .Clear(b_clear), .Done(b_done), .sum(b_sum),
        .acc_total(b_total), .acc_valid(b_valid), .acc_ready(b_ready), .count(b_count),
        .wrap(b_wrap), .overrun(b_ovr)
`ifdef SUM_MAX_TRACK_EN
        , .acc_max(b_max)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       clr, done;
        logic [4:0] sum;
        logic       rdy;
        int         reps;
        logic [7:0] total;
        logic       valid;
        logic [2:0] cnt;
        logic       wrap, ovr;
        logic [4:0] mx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic clr, logic done, logic [4:0] sum, logic rdy, int reps,
                                logic [7:0] total, logic valid, logic [2:0] cnt,
                                logic wrap, logic ovr, logic [4:0] mx);
        vec_t v;
        v.clr = clr; v.done = done; v.sum = sum; v.rdy = rdy; v.reps = reps;
        v.total = total; v.valid = valid; v.cnt = cnt; v.wrap = wrap; v.ovr = ovr; v.mx = mx;
        return v;
    endfunction

    task automatic check_a(input string tag, input logic [7:0] total, input logic valid,
                           input logic [2:0] cnt, input logic wrap, input logic ovr, input logic [4:0] mx);
        check({tag, " total"}, 32'(a_total), 32'(total));
        check({tag, " valid"}, 32'(a_valid), 32'(valid));
        check({tag, " count"}, 32'(a_count), 32'(cnt));
        check({tag, " wrap"}, 32'(a_wrap), 32'(wrap));
        check({tag, " overrun"}, 32'(a_ovr), 32'(ovr));
`ifdef SUM_MAX_TRACK_EN
        check({tag, " max"}, 32'(a_max), 32'(mx));
`endif
    endtask

    task automatic step_a(input logic done, input logic [4:0] sum, input logic rdy);
        a_clear = 1'b0; a_done = done; a_sum = sum; a_ready = rdy;
        @(posedge clock); #1;
    endtask

    task automatic step_b(input logic done, input logic [4:0] sum, input logic rdy);
        b_done = done; b_sum = sum; b_ready = rdy;
        @(posedge clock); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_clear = 0; a_done = 0; a_sum = 0; a_ready = 0;
        b_clear = 0; b_done = 0; b_sum = 0; b_ready = 0;
        #2;
        check_a("reset", 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
        check("reset b total", 32'(b_total), 32'd0);
        check("reset b valid", 32'(b_valid), 32'd0);
        @(posedge clock); #1;
        rst_n = 1'b1;

        // Block of 3,7,10,31 with gaps; ready held high throughout.
        tbl.push_back(mk(0,1, 3,1,1,  3,0,1,0,0, 3));
        tbl.push_back(mk(0,0, 0,1,4,  3,0,1,0,0, 3));
        tbl.push_back(mk(0,1, 7,1,1, 10,0,2,0,0, 7));
        tbl.push_back(mk(0,0, 0,1,4, 10,0,2,0,0, 7));
        tbl.push_back(mk(0,1,10,1,1, 20,0,3,0,0,10));
        tbl.push_back(mk(0,0, 0,1,4, 20,0,3,0,0,10));
        tbl.push_back(mk(0,1,31,1,1, 51,1,4,0,0,31));
        tbl.push_back(mk(0,0, 0,1,2,  0,0,0,0,0, 0));
        // Block of 20 held, sum 9 dropped -> overrun
        tbl.push_back(mk(0,1, 5,0,1,  5,0,1,0,0, 5));
        tbl.push_back(mk(0,1, 5,0,1, 10,0,2,0,0, 5));
        tbl.push_back(mk(0,1, 5,0,1, 15,0,3,0,0, 5));
        tbl.push_back(mk(0,1, 5,0,1, 20,1,4,0,0, 5));
        tbl.push_back(mk(0,0, 0,0,10,20,1,4,0,0, 5));
        tbl.push_back(mk(0,1, 9,0,1, 20,1,4,0,1, 5));
        tbl.push_back(mk(0,0, 0,0,2, 20,1,4,0,1, 5));
        tbl.push_back(mk(0,0, 0,1,1,  0,0,0,0,1, 0));
        tbl.push_back(mk(0,0, 0,1,2,  0,0,0,0,1, 0));
        // Simultaneous handshake + Done starts the next block
        tbl.push_back(mk(0,1, 4,0,1,  4,0,1,0,1, 4));
        tbl.push_back(mk(0,1, 4,0,1,  8,0,2,0,1, 4));
        tbl.push_back(mk(0,1, 4,0,1, 12,0,3,0,1, 4));
        tbl.push_back(mk(0,1, 4,0,1, 16,1,4,0,1, 4));
        tbl.push_back(mk(0,1,12,1,1, 12,0,1,0,1,12));
        tbl.push_back(mk(0,1, 1,0,1, 13,0,2,0,1,12));
        tbl.push_back(mk(0,1, 1,0,1, 14,0,3,0,1,12));
        tbl.push_back(mk(0,1, 1,0,1, 15,1,4,0,1,12));
        tbl.push_back(mk(0,0, 0,0,1, 15,1,4,0,1,12));
        tbl.push_back(mk(0,0, 0,1,1,  0,0,0,0,1, 0));
        // Clear beats a same-edge Done; zero sums still count
        tbl.push_back(mk(0,1, 2,0,1,  2,0,1,0,1, 2));
        tbl.push_back(mk(0,1, 2,0,1,  4,0,2,0,1, 2));
        tbl.push_back(mk(0,1, 2,0,1,  6,0,3,0,1, 2));
        tbl.push_back(mk(1,1, 6,0,1,  0,0,0,0,0, 0));
        tbl.push_back(mk(0,0, 0,0,1,  0,0,0,0,0, 0));
        tbl.push_back(mk(0,1, 1,0,1,  1,0,1,0,0, 1));
        tbl.push_back(mk(0,1, 0,0,1,  1,0,2,0,0, 1));
        tbl.push_back(mk(1,0, 0,0,1,  0,0,0,0,0, 0));

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                a_clear = tbl[i].clr; a_done = tbl[i].done; a_sum = tbl[i].sum; a_ready = tbl[i].rdy;
                @(posedge clock); #1;
                check_a($sformatf("v%0d.%0d", i, r), tbl[i].total, tbl[i].valid, tbl[i].cnt,
                        tbl[i].wrap, tbl[i].ovr, tbl[i].mx);
            end
        end

        // Narrow accumulator: 31+31+2+0 = 64 -> 0 with wrap
        step_b(1'b1, 5'd31, 1'b0);
        step_b(1'b1, 5'd31, 1'b0);
        check("b wrap mid", 32'(b_wrap), 32'd1);
        check("b total mid", 32'(b_total), 32'd30);
        step_b(1'b1, 5'd2, 1'b0);
        step_b(1'b1, 5'd0, 1'b0);
        check("b total", 32'(b_total), 32'd0);
        check("b valid", 32'(b_valid), 32'd1);
        check("b wrap", 32'(b_wrap), 32'd1);
        check("b count", 32'(b_count), 32'd4);
        step_b(1'b0, 5'd0, 1'b1);
        check("b valid after hs", 32'(b_valid), 32'd0);
        check("b wrap after hs", 32'(b_wrap), 32'd0);
        step_b(1'b0, 5'd0, 1'b0);

        // Async reset mid-block, Done ignored while in reset
        step_a(1'b1, 5'd9, 1'b0);
        step_a(1'b1, 5'd8, 1'b0);
        check_a("pre-reset", 8'd17, 1'b0, 3'd2, 1'b0, 1'b0, 5'd9);
        #2 rst_n = 1'b0;
        #1;
        check_a("async reset", 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
        a_done = 1'b1; a_sum = 5'd20;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_a("in reset", 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);
        a_done = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clock); #1;
        step_a(1'b1, 5'd1, 1'b0);
        step_a(1'b1, 5'd2, 1'b0);
        step_a(1'b1, 5'd3, 1'b0);
        step_a(1'b1, 5'd4, 1'b0);
        check_a("post-reset block", 8'd10, 1'b1, 3'd4, 1'b0, 1'b0, 5'd4);
        step_a(1'b0, 5'd0, 1'b1);
        check_a("post-reset hs", 8'd0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
